// File: rtl/mc_defs_pkg.sv
//------------------------------------------------------------------------------
// mc_defs : shared definitions for the multi-cycle MIPS control unit
//           (ALU codes, opcode/funct codes, state encodings, mux selects)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mc_defs;

  localparam int         PC_INC    = 4;
  localparam logic [3:0] RST_STATE = 4'd0;

  localparam logic [3:0] ALU_NOP  = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_NOR  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_ADDU = 4'b1001;
  localparam logic [3:0] ALU_SUBU = 4'b1010;
  localparam logic [3:0] ALU_SLL  = 4'b1011;
  localparam logic [3:0] ALU_LUI  = 4'b1100;
  localparam logic [3:0] ALU_SRL  = 4'b1101;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] FUNCT_SLLV = 6'b000100;
  localparam logic [5:0] FUNCT_SRLV = 6'b000110;
  localparam logic [5:0] FUNCT_JR   = 6'b001000;
  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_ADDU = 6'b100001;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_SUBU = 6'b100011;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_NOR  = 6'b100111;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;
  localparam logic [5:0] FUNCT_SLTU = 6'b101011;

  typedef enum logic [3:0] {
    S_FETCH    = RST_STATE,
    S_DECODE   = 4'd1,
    S_EXE_R    = 4'd2,
    S_EXE_I    = 4'd3,
    S_WB_ALU   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WB   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_JR       = 4'd11
  } state_t;

  localparam logic [1:0] SRCA_PC      = 2'b00;
  localparam logic [1:0] SRCA_REGA    = 2'b01;
  localparam logic [1:0] SRCA_SHAMT   = 2'b10;
  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;
  localparam logic [1:0] PCS_ALU      = 2'b00;
  localparam logic [1:0] PCS_ALUOUT   = 2'b01;
  localparam logic [1:0] PCS_JUMP     = 2'b10;
  localparam logic [1:0] PCS_REGA     = 2'b11;
  localparam logic [1:0] DST_RT       = 2'b00;
  localparam logic [1:0] DST_RD       = 2'b01;
  localparam logic [1:0] DST_RA       = 2'b10;
  localparam logic [1:0] WD_ALUOUT    = 2'b00;
  localparam logic [1:0] WD_MDR       = 2'b01;
  localparam logic [1:0] WD_PC        = 2'b10;

endpackage

`default_nettype wire

// File: rtl/mc_ctrl_alu_dec.sv
//------------------------------------------------------------------------------
// alu_dec : combinational Op/Funct decode to ALU opcode, extension mode,
//           A-operand select, destination-is-rd flag and illegal flag
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_dec
  import mc_defs::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output logic [3:0] o_aluop,
  output logic       o_extop,
  output logic [1:0] o_srca,
  output logic       o_dst_rd,
  output logic       o_illegal
);

  always_comb begin
    o_aluop   = ALU_NOP;
    o_extop   = 1'b0;
    o_srca    = SRCA_REGA;
    o_dst_rd  = 1'b0;
    o_illegal = 1'b0;
    case (i_op)
      OP_RTYPE: begin
        o_dst_rd = 1'b1;
        case (i_funct)
          FUNCT_ADD:  o_aluop = ALU_ADD;
          FUNCT_ADDU: o_aluop = ALU_ADDU;
          FUNCT_SUB:  o_aluop = ALU_SUB;
          FUNCT_SUBU: o_aluop = ALU_SUBU;
          FUNCT_AND:  o_aluop = ALU_AND;
          FUNCT_OR:   o_aluop = ALU_OR;
          FUNCT_NOR:  o_aluop = ALU_NOR;
          FUNCT_SLT:  o_aluop = ALU_SLT;
          FUNCT_SLTU: o_aluop = ALU_SLTU;
          // Immediate shifts take the shift amount from IR[10:6].
          FUNCT_SLL: begin
            o_aluop = ALU_SLL;
            o_srca  = SRCA_SHAMT;
          end
          FUNCT_SRL: begin
            o_aluop = ALU_SRL;
            o_srca  = SRCA_SHAMT;
          end
          FUNCT_SLLV: o_aluop = ALU_SLL;
          FUNCT_SRLV: o_aluop = ALU_SRL;
          FUNCT_JR:   o_aluop = ALU_NOP;
          default:    o_illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin
        o_aluop = ALU_ADD;
        o_extop = 1'b1;
      end
      OP_ANDI: o_aluop = ALU_AND;
      OP_ORI:  o_aluop = ALU_OR;
      OP_SLTI: begin
        o_aluop = ALU_SLT;
        o_extop = 1'b1;
      end
      OP_LUI:  o_aluop = ALU_LUI;
      OP_LW, OP_SW: begin
        o_aluop = ALU_ADD;
        o_extop = 1'b1;
      end
      OP_BEQ, OP_BNE: o_aluop = ALU_SUB;
      OP_J, OP_JAL: begin
        o_aluop = ALU_NOP;
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mc_ctrl.sv
//------------------------------------------------------------------------------
// mc_ctrl : multi-cycle MIPS control unit; sequences FETCH/DECODE/EXECUTE/
//           MEMORY/WRITEBACK and drives all datapath enables and selects
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mc_ctrl
  import mc_defs::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic [3:0] ALUop,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       EXTOp,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic [1:0] PCSource,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] WDSel,
  output logic       illegal,
  output logic [3:0] state
);

  state_t     r_state;
  logic       r_dst_rd;
  logic [3:0] w_aluop;
  logic       w_extop;
  logic [1:0] w_srca;
  logic       w_dst_rd;
  logic       w_illegal;

  alu_dec u_alu_dec (
    .i_op      (Op),
    .i_funct   (Funct),
    .o_aluop   (w_aluop),
    .o_extop   (w_extop),
    .o_srca    (w_srca),
    .o_dst_rd  (w_dst_rd),
    .o_illegal (w_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_FETCH;
      r_dst_rd <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
          r_dst_rd <= w_dst_rd;
          if (w_illegal) begin
            r_state <= S_FETCH;
          end else begin
            case (Op)
              OP_RTYPE: r_state <= (Funct == FUNCT_JR) ? S_JR : S_EXE_R;
              OP_LW, OP_SW: r_state <= S_MEM_ADDR;
              OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI: r_state <= S_EXE_I;
              OP_BEQ, OP_BNE: r_state <= S_BRANCH;
              OP_J, OP_JAL: r_state <= S_JUMP;
              default: r_state <= S_FETCH;
            endcase
          end
        end
        S_EXE_R, S_EXE_I: r_state <= S_WB_ALU;
        S_MEM_ADDR: r_state <= (Op == OP_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD: r_state <= S_MEM_WB;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign state = r_state;

  // Outputs are forced idle while rst is held so FETCH strobes cannot fire.
  always_comb begin
    ALUop    = ALU_NOP;
    ALUSrcA  = SRCA_PC;
    ALUSrcB  = SRCB_REGB;
    EXTOp    = 1'b0;
    IorD     = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCSource = PCS_ALU;
    RegWrite = 1'b0;
    RegDst   = DST_RT;
    WDSel    = WD_ALUOUT;
    illegal  = 1'b0;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          IRWrite = 1'b1;
          ALUSrcB = SRCB_FOUR;
          ALUop   = ALU_ADD;
          PCWrite = 1'b1;
        end
        S_DECODE: begin
          ALUSrcB = SRCB_IMM_SH2;
          EXTOp   = 1'b1;
          ALUop   = ALU_ADD;
          illegal = w_illegal;
        end
        S_EXE_R: begin
          ALUop   = w_aluop;
          ALUSrcA = w_srca;
        end
        S_EXE_I: begin
          ALUop   = w_aluop;
          EXTOp   = w_extop;
          ALUSrcA = SRCA_REGA;
          ALUSrcB = SRCB_IMM;
        end
        S_WB_ALU: begin
          RegWrite = 1'b1;
          RegDst   = r_dst_rd ? DST_RD : DST_RT;
        end
        S_MEM_ADDR: begin
          ALUSrcA = SRCA_REGA;
          ALUSrcB = SRCB_IMM;
          EXTOp   = 1'b1;
          ALUop   = ALU_ADD;
        end
        S_MEM_RD: IorD = 1'b1;
        S_MEM_WB: begin
          RegWrite = 1'b1;
          WDSel    = WD_MDR;
        end
        S_MEM_WR: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA  = SRCA_REGA;
          ALUop    = ALU_SUB;
          PCSource = PCS_ALUOUT;
          PCWrite  = (Op == OP_BEQ) ? Zero : ~Zero;
        end
        S_JUMP: begin
          PCSource = PCS_JUMP;
          PCWrite  = 1'b1;
          if (Op == OP_JAL) begin
            RegWrite = 1'b1;
            RegDst   = DST_RA;
            WDSel    = WD_PC;
          end
        end
        S_JR: begin
          PCSource = PCS_REGA;
          PCWrite  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mc_ctrl.sv
//------------------------------------------------------------------------------
// tb_mc_ctrl : self-checking bench for mc_ctrl against an instruction-level
//              reference model
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_mc_ctrl;
  import mc_defs::*;

  logic       clk, rst, Zero;
  logic [5:0] Op, Funct;
  logic [3:0] ALUop, state;
  logic [1:0] ALUSrcA, ALUSrcB, PCSource, RegDst, WDSel;
  logic       EXTOp, IorD, MemWrite, IRWrite, PCWrite, RegWrite, illegal;

  mc_ctrl dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero),
    .ALUop(ALUop), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .EXTOp(EXTOp),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCSource(PCSource), .RegWrite(RegWrite), .RegDst(RegDst), .WDSel(WDSel),
    .illegal(illegal), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] aluop;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic       extop, iord, memw, irw, pcw;
    logic [1:0] pcsrc;
    logic       regw;
    logic [1:0] regdst;
    logic [1:0] wdsel;
    logic       ill;
  } obs_t;

  typedef enum {K_R, K_JR, K_I, K_LW, K_SW, K_BR, K_J, K_ILL} kind_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic mon_en   = 1'b0;
  logic seen_rw  = 1'b0;

  always @(posedge RegWrite) if (mon_en) seen_rw = 1'b1;

  function automatic obs_t observe();
    return {state, ALUop, ALUSrcA, ALUSrcB, EXTOp, IorD, MemWrite, IRWrite,
            PCWrite, PCSource, RegWrite, RegDst, WDSel, illegal};
  endfunction

  function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000000: begin
        if (fn == 6'b001000) return K_JR;
        if (fn inside {6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd39,
                       6'd42, 6'd43, 6'd0, 6'd2, 6'd4, 6'd6}) return K_R;
        return K_ILL;
      end
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b001111: return K_I;
      6'b000100, 6'b000101: return K_BR;
      6'b000010, 6'b000011: return K_J;
      default: return K_ILL;
    endcase
  endfunction

  function automatic int cycles(input kind_t kd);
    case (kd)
      K_R, K_I, K_SW: return 4;
      K_LW:           return 5;
      K_BR, K_J, K_JR: return 3;
      default:        return 2;
    endcase
  endfunction

  function automatic logic [3:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'd32: return 4'b0001;
      6'd33: return 4'b1001;
      6'd34: return 4'b0010;
      6'd35: return 4'b1010;
      6'd36: return 4'b0011;
      6'd37: return 4'b0100;
      6'd39: return 4'b0110;
      6'd42: return 4'b0111;
      6'd43: return 4'b1000;
      6'd0, 6'd4: return 4'b1011;
      6'd2, 6'd6: return 4'b1101;
      default: return 4'b0000;
    endcase
  endfunction

  // Expected outputs in cycle k of one instruction.
  function automatic obs_t model(input logic [5:0] op, input logic [5:0] fn,
                                 input logic z, input int k);
    obs_t  e  = '0;
    kind_t kd = classify(op, fn);
    if (k == 0) begin
      e.st = S_FETCH; e.irw = 1; e.srcb = 2'b01; e.aluop = 4'b0001; e.pcw = 1;
    end else if (k == 1) begin
      e.st = S_DECODE; e.srcb = 2'b11; e.extop = 1; e.aluop = 4'b0001;
      e.ill = (kd == K_ILL);
    end else begin
      case (kd)
        K_R: if (k == 2) begin
          e.st = S_EXE_R; e.aluop = r_alu(fn);
          e.srca = (fn == 6'd0 || fn == 6'd2) ? 2'b10 : 2'b01;
        end else begin
          e.st = S_WB_ALU; e.regw = 1; e.regdst = 2'b01;
        end
        K_I: if (k == 2) begin
          e.st = S_EXE_I; e.srca = 2'b01; e.srcb = 2'b10;
          case (op)
            6'b001000: begin e.aluop = 4'b0001; e.extop = 1; end
            6'b001100: e.aluop = 4'b0011;
            6'b001101: e.aluop = 4'b0100;
            6'b001010: begin e.aluop = 4'b0111; e.extop = 1; end
            default:   e.aluop = 4'b1100;
          endcase
        end else begin
          e.st = S_WB_ALU; e.regw = 1; e.regdst = 2'b00;
        end
        K_LW, K_SW: if (k == 2) begin
          e.st = S_MEM_ADDR; e.srca = 2'b01; e.srcb = 2'b10; e.extop = 1;
          e.aluop = 4'b0001;
        end else if (kd == K_SW) begin
          e.st = S_MEM_WR; e.iord = 1; e.memw = 1;
        end else if (k == 3) begin
          e.st = S_MEM_RD; e.iord = 1;
        end else begin
          e.st = S_MEM_WB; e.regw = 1; e.wdsel = 2'b01;
        end
        K_BR: begin
          e.st = S_BRANCH; e.srca = 2'b01; e.aluop = 4'b0010; e.pcsrc = 2'b01;
          e.pcw = (op == 6'b000100) ? z : !z;
        end
        K_J: begin
          e.st = S_JUMP; e.pcsrc = 2'b10; e.pcw = 1;
          if (op == 6'b000011) begin
            e.regw = 1; e.regdst = 2'b10; e.wdsel = 2'b10;
          end
        end
        K_JR: begin
          e.st = S_JR; e.pcsrc = 2'b11; e.pcw = 1;
        end
        default: ;
      endcase
    end
    return e;
  endfunction

  // Runs cycles k0..end of one instruction; entered and left at posedge+1.
  task automatic run_instr(input string name, input logic [5:0] op,
                           input logic [5:0] fn, input logic z, input int k0);
    obs_t exp_v, got;
    int   n = cycles(classify(op, fn));
    for (int k = k0; k < n; k++) begin
      Op = op; Funct = fn; Zero = z;
      #1;
      exp_v = model(op, fn, z, k);
      got   = observe();
      n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %h required %h", name, k, got, exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; Op = '0; Funct = '0; Zero = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (state !== 4'd0 || {PCWrite, IRWrite, MemWrite, RegWrite, illegal} !== 5'b0 ||
        ALUop !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_state: state %h strobes %b ALUop %h required 0 00000 0",
               state, {PCWrite, IRWrite, MemWrite, RegWrite, illegal}, ALUop);
    end
    rst = 1'b0;
  endtask

  task automatic test_add();
    run_instr("add", 6'b000000, 6'b100000, 1'b0, 0);
    n_checks++;
    if (state !== S_FETCH) begin
      n_fail++;
      $display("FAIL add_len: state %h after 4 cycles required %h", state, S_FETCH);
    end
  endtask

  task automatic test_back_to_back();
    run_instr("lw", 6'b100011, 6'b010101, 1'b1, 0);
    run_instr("sw", 6'b101011, 6'b000000, 1'b0, 0);
    n_checks++;
    if (state !== S_FETCH) begin
      n_fail++;
      $display("FAIL sw_len: state %h required %h", state, S_FETCH);
    end
  endtask

  task automatic test_branch();
    run_instr("beq_z1", 6'b000100, 6'b000000, 1'b1, 0);
    run_instr("beq_z0", 6'b000100, 6'b000000, 1'b0, 0);
    run_instr("bne_z0", 6'b000101, 6'b000000, 1'b0, 0);
    run_instr("bne_z1", 6'b000101, 6'b000000, 1'b1, 0);
    run_instr("jr",     6'b000000, 6'b001000, 1'b0, 0);
  endtask

  task automatic test_shift_lui();
    run_instr("sll",  6'b000000, 6'b000000, 1'b0, 0);
    run_instr("sllv", 6'b000000, 6'b000100, 1'b0, 0);
    run_instr("srl",  6'b000000, 6'b000010, 1'b1, 0);
    run_instr("lui",  6'b001111, 6'b111111, 1'b0, 0);
  endtask

  task automatic test_illegal_jal();
    mon_en = 1'b1; seen_rw = 1'b0;
    run_instr("illegal_op", 6'b111111, 6'b100000, 1'b0, 0);
    run_instr("illegal_fn", 6'b000000, 6'b111111, 1'b0, 0);
    mon_en = 1'b0;
    n_checks++;
    if (seen_rw !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_nowrite: RegWrite seen %b required 0", seen_rw);
    end
    run_instr("jal", 6'b000011, 6'b000000, 1'b0, 0);
    run_instr("j",   6'b000010, 6'b000000, 1'b1, 0);
  endtask

  task automatic test_reset_mid_lw();
    obs_t exp_v, got;
    run_instr("lw_pre", 6'b100011, 6'b000000, 1'b0, 0);
    // Now restart lw and abort it in MEM_RD.
    for (int k = 0; k < 3; k++) begin
      Op = 6'b100011; Funct = '0; Zero = 1'b0;
      @(posedge clk); #1;
    end
    mon_en = 1'b1; seen_rw = 1'b0;
    n_checks++;
    if (state !== S_MEM_RD) begin
      n_fail++;
      $display("FAIL rst_pre_memrd: state %h required %h", state, S_MEM_RD);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (state !== S_FETCH || {PCWrite, IRWrite, MemWrite, RegWrite} !== 4'b0 ||
        ALUop !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_async: state %h strobes %b ALUop %h required 0 0000 0",
               state, {PCWrite, IRWrite, MemWrite, RegWrite}, ALUop);
    end
    @(posedge clk); #1;
    n_checks++;
    if (state !== S_FETCH || IRWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_hold: state %h IRWrite %b required 0 0", state, IRWrite);
    end
    rst = 1'b0;
    #1;
    exp_v = model(6'b100011, 6'b000000, 1'b0, 0);
    got   = observe();
    n_checks++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL rst_release_fetch: got %h required %h", got, exp_v);
    end
    @(posedge clk); #1;
    mon_en = 1'b0;
    n_checks++;
    if (seen_rw !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_nowrite: RegWrite seen %b required 0", seen_rw);
    end
    run_instr("lw_after_rst", 6'b100011, 6'b000000, 1'b0, 1);
  endtask

  task automatic test_random();
    logic [5:0] ops [12] = '{6'b000000, 6'b000000, 6'b100011, 6'b101011,
                             6'b001000, 6'b001100, 6'b001101, 6'b001010,
                             6'b001111, 6'b000100, 6'b000101, 6'b000011};
    logic [5:0] fns [14] = '{6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd39,
                             6'd42, 6'd43, 6'd0, 6'd2, 6'd4, 6'd6, 6'd8};
    logic [5:0] op, fn;
    for (int i = 0; i < 80; i++) begin
      op = ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 11)] : 6'($urandom);
      fn = ($urandom_range(0, 9) < 7) ? fns[$urandom_range(0, 13)] : 6'($urandom);
      run_instr("random", op, fn, 1'($urandom), 0);
    end
    n_checks++;
    if (state !== S_FETCH) begin
      n_fail++;
      $display("FAIL random_end: state %h required %h", state, S_FETCH);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_branch();
    test_shift_lui();
    test_illegal_jal();
    test_reset_mid_lw();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
